instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: next-PC selection, single-outstanding instruction
// memory request, and the instruction/PC registers feeding decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcEn,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        btaken,
  input  logic [31:0] immExt,
  input  logic [31:0] rs1Data,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemRData,
  output logic [31:0] instrCode,
  output logic [31:0] pcOut,
  output logic [31:0] pcPlus4,
  output logic        instrValid,
  output logic        fetchBusy,
  output logic        misalign
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        first_q, first_d;
  logic [31:0] target;
  logic [31:0] jalr_sum;

  // Next-PC candidate, highest-priority source first.
  always_comb begin
    jalr_sum = rs1Data + immExt;
    target   = pc_q + 32'd4;
    if (first_q) begin
      target = RESET_PC;
    end else if (jal && jalr) begin
      target = {jalr_sum[31:1], 1'b0};
    end else if (jal) begin
      target = pc_q + immExt;
    end else if (branch && btaken) begin
      target = pc_q + immExt;
    end
  end

  // Fetch FSM next-state and register updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    first_d = first_q;
    unique case (state_q)
      IDLE: begin
        if (pcEn) begin
          if (target[1:0] == 2'b00) begin
            pc_d    = target;
            first_d = 1'b0;
            valid_d = 1'b0;
            state_d = REQ;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (imemReady) begin
          instr_d = imemRData;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      first_q <= first_d;
    end
  end

  assign imemReq    = (state_q == REQ);
  assign fetchBusy  = (state_q == REQ);
  assign imemAddr   = pc_q;
  assign pcOut      = pc_q;
  assign pcPlus4    = pc_q + 32'd4;
  assign instrCode  = instr_q;
  assign instrValid = valid_q;
  assign misalign   = mis_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of expected
// (pc, instruction) pairs pushed at pcEn and popped at capture.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0, pcEn = 1'b0, branch = 1'b0, jal = 1'b0, jalr = 1'b0, btaken = 1'b0;
  logic [31:0] immExt = '0, rs1Data = '0;
  logic        imemReq, imemReady = 1'b0;
  logic [31:0] imemAddr, imemRData = '0;
  logic [31:0] instrCode, pcOut, pcPlus4;
  logic        instrValid, fetchBusy, misalign;

  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} exp_t;
  typedef struct packed {logic br; logic bt; logic j; logic jr; logic [31:0] imm; logic [31:0] tgt;} step_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pcEn(pcEn), .branch(branch), .jal(jal), .jalr(jalr),
    .btaken(btaken), .immExt(immExt), .rs1Data(rs1Data), .imemReq(imemReq),
    .imemAddr(imemAddr), .imemReady(imemReady), .imemRData(imemRData),
    .instrCode(instrCode), .pcOut(pcOut), .pcPlus4(pcPlus4), .instrValid(instrValid),
    .fetchBusy(fetchBusy), .misalign(misalign)
  );

  // Bench-side instruction memory contents.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : ((a ^ 32'h5A5A_0000) | 32'h3);
  endfunction

  // Pulse pcEn with the given control inputs, then serve the request after
  // `waits` wait states. Called and returns on a falling edge.
  task automatic do_fetch(input logic br, input logic bt, input logic j, input logic jr,
                          input logic [31:0] imm, input logic [31:0] rs1, input int waits,
                          output int nreq, output logic stable, output logic done);
    logic [31:0] a0;
    nreq = 0; stable = 1'b1; done = 1'b0; a0 = '0;
    branch = br; btaken = bt; jal = j; jalr = jr; immExt = imm; rs1Data = rs1; pcEn = 1'b1;
    @(negedge clk);
    pcEn = 1'b0; branch = 1'b0; btaken = 1'b0; jal = 1'b0; jalr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!imemReq) begin
        done = (nreq > 0);
        break;
      end
      if (nreq == 0) a0 = imemAddr;
      else if (imemAddr !== a0) stable = 1'b0;
      nreq++;
      imemReady = (nreq > waits);
      imemRData = imemReady ? memw(imemAddr) : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    imemReady = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (pcOut !== RST_PC) $display("FAIL reset_pc: got %h exp %h", pcOut, RST_PC); else passed++;
    total++; if (instrCode !== NOP) $display("FAIL reset_instr: got %h exp %h", instrCode, NOP); else passed++;
    total++; if (instrValid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", instrValid); else passed++;
    total++; if (misalign !== 1'b0) $display("FAIL reset_misalign: got %b exp 0", misalign); else passed++;
    total++; if ({imemReq, fetchBusy} !== 2'b00) $display("FAIL reset_req: got %b exp 00", {imemReq, fetchBusy}); else passed++;
    total++; if (pcPlus4 !== 32'h4) $display("FAIL reset_pcplus4: got %h exp 4", pcPlus4); else passed++;
  endtask

  task automatic test_first_fetch;
    int n; logic st, dn; exp_t e;
    sbq.push_back('{pc: 32'h0, instr: 32'h0050_0093});
    do_fetch(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0, n, st, dn);
    total++; if (n !== 1) $display("FAIL first_req_cycles: got %0d exp 1", n); else passed++;
    total++; if (!dn) $display("FAIL first_capture: got %b exp 1", dn); else passed++;
    e = sbq.pop_front();
    total++; if (pcOut !== e.pc) $display("FAIL first_pc: got %h exp %h", pcOut, e.pc); else passed++;
    total++; if (instrCode !== e.instr) $display("FAIL first_instr: got %h exp %h", instrCode, e.instr); else passed++;
    total++; if (instrValid !== 1'b1) $display("FAIL first_valid: got %b exp 1", instrValid); else passed++;
  endtask

  task automatic test_sequential;
    int n; logic st, dn; exp_t e;
    for (int k = 1; k <= 4; k++) begin
      sbq.push_back('{pc: 32'(4 * k), instr: memw(32'(4 * k))});
      do_fetch(1'b0, 1'b0, 1'b0, 1'b0, 32'h40, '0, k % 2, n, st, dn);
      total++; if (!dn) $display("FAIL seq_capture: got %b exp 1 (step %0d)", dn, k); else passed++;
      e = sbq.pop_front();
      total++; if ({pcOut, instrCode} !== {e.pc, e.instr})
        $display("FAIL seq_pc_instr: got %h/%h exp %h/%h", pcOut, instrCode, e.pc, e.instr); else passed++;
    end
  endtask

  task automatic test_wait_states;
    int n; logic st, dn; exp_t e;
    sbq.push_back('{pc: 32'h14, instr: memw(32'h14)});
    do_fetch(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3, n, st, dn);
    total++; if (n !== 4) $display("FAIL wait_req_cycles: got %0d exp 4", n); else passed++;
    total++; if (st !== 1'b1) $display("FAIL wait_addr_stable: got %b exp 1", st); else passed++;
    e = sbq.pop_front();
    total++; if ({pcOut, instrCode} !== {e.pc, e.instr})
      $display("FAIL wait_pc_instr: got %h/%h exp %h/%h", pcOut, instrCode, e.pc, e.instr); else passed++;
    total++; if (instrValid !== 1'b1) $display("FAIL wait_valid: got %b exp 1", instrValid); else passed++;
    total++; if (pcPlus4 !== 32'h18) $display("FAIL wait_pcplus4: got %h exp 18", pcPlus4); else passed++;
  endtask

  task automatic test_branch_jal;
    int n; logic st, dn; exp_t e; step_t s[4];
    s[0] = '{br: 1'b1, bt: 1'b1, j: 1'b0, jr: 1'b0, imm: 32'h0000_000C, tgt: 32'h20};
    s[1] = '{br: 1'b1, bt: 1'b1, j: 1'b0, jr: 1'b0, imm: 32'hFFFF_FFF8, tgt: 32'h18};
    s[2] = '{br: 1'b0, bt: 1'b0, j: 1'b1, jr: 1'b0, imm: 32'h0000_0008, tgt: 32'h20};
    s[3] = '{br: 1'b1, bt: 1'b0, j: 1'b0, jr: 1'b0, imm: 32'hFFFF_FFF8, tgt: 32'h24};
    for (int k = 0; k < 4; k++) begin
      sbq.push_back('{pc: s[k].tgt, instr: memw(s[k].tgt)});
      do_fetch(s[k].br, s[k].bt, s[k].j, s[k].jr, s[k].imm, 32'h7777_0000, 0, n, st, dn);
      total++; if (!dn) $display("FAIL br_capture: got %b exp 1 (step %0d)", dn, k); else passed++;
      e = sbq.pop_front();
      total++; if ({pcOut, instrCode} !== {e.pc, e.instr})
        $display("FAIL br_pc_instr: got %h/%h exp %h/%h (step %0d)", pcOut, instrCode, e.pc, e.instr, k); else passed++;
    end
  endtask

  task automatic test_jalr_misalign;
    int n; logic st, dn; exp_t e;
    sbq.push_back('{pc: 32'h104, instr: memw(32'h104)});
    do_fetch(1'b0, 1'b0, 1'b1, 1'b1, 32'h3, 32'h101, 0, n, st, dn);
    e = sbq.pop_front();
    total++; if ({pcOut, instrCode} !== {e.pc, e.instr})
      $display("FAIL jalr_pc_instr: got %h/%h exp %h/%h", pcOut, instrCode, e.pc, e.instr); else passed++;
    total++; if (misalign !== 1'b0) $display("FAIL jalr_no_misalign: got %b exp 0", misalign); else passed++;
    // Misaligned JALR target: no request, state untouched.
    do_fetch(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h102, 0, n, st, dn);
    total++; if (n !== 0) $display("FAIL mis_no_req: got %0d req cycles exp 0", n); else passed++;
    total++; if (misalign !== 1'b1) $display("FAIL mis_flag: got %b exp 1", misalign); else passed++;
    total++; if ({pcOut, instrCode, instrValid} !== {32'h104, memw(32'h104), 1'b1})
      $display("FAIL mis_hold: got %h/%h/%b exp %h/%h/1", pcOut, instrCode, instrValid, 32'h104, memw(32'h104)); else passed++;
    // Sticky flag survives a good fetch.
    sbq.push_back('{pc: 32'h108, instr: memw(32'h108)});
    do_fetch(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1, n, st, dn);
    e = sbq.pop_front();
    total++; if ({pcOut, instrCode} !== {e.pc, e.instr})
      $display("FAIL sticky_pc_instr: got %h/%h exp %h/%h", pcOut, instrCode, e.pc, e.instr); else passed++;
    total++; if (misalign !== 1'b1) $display("FAIL mis_sticky: got %b exp 1", misalign); else passed++;
    // Wrap at the top of the address space.
    sbq.push_back('{pc: 32'hFFFF_FFFC, instr: memw(32'hFFFF_FFFC)});
    do_fetch(1'b0, 1'b0, 1'b1, 1'b1, 32'hC, 32'hFFFF_FFF0, 0, n, st, dn);
    e = sbq.pop_front();
    total++; if (pcOut !== e.pc) $display("FAIL top_pc: got %h exp %h", pcOut, e.pc); else passed++;
    total++; if (pcPlus4 !== 32'h0) $display("FAIL pcplus4_wrap: got %h exp 0", pcPlus4); else passed++;
    sbq.push_back('{pc: 32'h0, instr: memw(32'h0)});
    do_fetch(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0, n, st, dn);
    e = sbq.pop_front();
    total++; if ({pcOut, instrCode} !== {e.pc, e.instr})
      $display("FAIL wrap_pc_instr: got %h/%h exp %h/%h", pcOut, instrCode, e.pc, e.instr); else passed++;
    // imemReady in IDLE has no effect.
    imemReady = 1'b1; imemRData = 32'h1234_5678;
    @(negedge clk);
    imemReady = 1'b0;
    total++; if ({instrCode, fetchBusy} !== {memw(32'h0), 1'b0})
      $display("FAIL idle_ready: got %h/%b exp %h/0", instrCode, fetchBusy, memw(32'h0)); else passed++;
  endtask

  task automatic test_req_pcen_reset;
    int n; logic st, dn; exp_t e;
    pcEn = 1'b1;
    @(negedge clk);
    pcEn = 1'b0;
    total++; if ({imemReq, imemAddr} !== {1'b1, 32'h4})
      $display("FAIL req_start: got %b/%h exp 1/%h", imemReq, imemAddr, 32'h4); else passed++;
    pcEn = 1'b1; jal = 1'b1; immExt = 32'h100;
    @(negedge clk);
    pcEn = 1'b0; jal = 1'b0;
    total++; if ({fetchBusy, imemAddr} !== {1'b1, 32'h4})
      $display("FAIL req_pcen_ignored: got %b/%h exp 1/%h", fetchBusy, imemAddr, 32'h4); else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({imemReq, pcOut, instrCode, instrValid, misalign} !== {1'b0, RST_PC, NOP, 1'b0, 1'b0})
      $display("FAIL abort_reset: got %b/%h/%h/%b/%b exp 0/%h/%h/0/0", imemReq, pcOut, instrCode, instrValid, misalign, RST_PC, NOP); else passed++;
    imemReady = 1'b1; imemRData = 32'h0BAD_0BAD;
    @(negedge clk);
    imemReady = 1'b0;
    total++; if ({imemReq, instrCode, instrValid} !== {1'b0, NOP, 1'b0})
      $display("FAIL late_ready: got %b/%h/%b exp 0/%h/0", imemReq, instrCode, instrValid, NOP); else passed++;
    // Reset wins over a simultaneous pcEn.
    reset = 1'b1; pcEn = 1'b1;
    @(negedge clk);
    reset = 1'b0; pcEn = 1'b0;
    total++; if (imemReq !== 1'b0) $display("FAIL reset_prio: got %b exp 0", imemReq); else passed++;
    // First fetch after reset goes to RESET_PC regardless of jal.
    sbq.push_back('{pc: RST_PC, instr: memw(RST_PC)});
    do_fetch(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, '0, 2, n, st, dn);
    e = sbq.pop_front();
    total++; if ({pcOut, instrCode, instrValid} !== {e.pc, e.instr, 1'b1})
      $display("FAIL first_after_reset: got %h/%h/%b exp %h/%h/1", pcOut, instrCode, instrValid, e.pc, e.instr); else passed++;
    total++; if (sbq.size() !== 0) $display("FAIL scoreboard_empty: got %0d exp 0", sbq.size()); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_sequential();
    test_wait_states();
    test_branch_jal();
    test_jalr_misalign();
    test_req_pcen_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
